ucode_loader: RTL

- Writer side of the microcode store: receives a byte stream from a serial receiver, assembles framed 32-bit microcode words, and writes them into the microcode RAM that the sequencer fetches from.
- Holds the sequencer halted while a load is in progress.
- Releases the sequencer on an explicit RUN command byte.
- Sits between the UART receive path and the microcode RAM write port.

---
 rtl/ucode_loader.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ucode_loader.sv
// ucode_loader: writer side of the microcode store.
// Assembles framed 32-bit microcode words from a UART byte stream and writes
// them into the microcode RAM, holding the sequencer halted while loading.
//
// Frame: SYNC_LOAD, AH, AL, D3, D2, D1, D0, CK
//   address = {AH[0], AL}, data = {D3,D2,D1,D0}, CK = xor of the six bytes.
//
// Ports:
//   clk        system clock, all logic on posedge
//   reset      synchronous active-high reset
//   rx_valid   one-cycle strobe, rx_data holds a new byte
//   rx_data    received byte
//   wr_en      one-cycle RAM write strobe
//   wr_addr    RAM word address (held until next write)
//   wr_data    RAM word (held until next write)
//   halt       1 = sequencer must not fetch
//   frame_ok   one-cycle pulse, frame accepted and written
//   frame_err  one-cycle pulse, frame aborted
//   err_code   last error: 00 none, 01 checksum, 10 timeout
//   word_count successful writes since reset, saturating at 1023
module ucode_loader #(
  parameter logic [7:0] SYNC_LOAD      = 8'hA5,
  parameter logic [7:0] SYNC_RUN       = 8'h5A,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter bit         HALT_ON_RESET  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        wr_en,
  output logic [8:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        halt,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic [9:0]  word_count
);

  localparam int             TW     = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0]  T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_DATA,
    S_CHECK
  } state_t;

  state_t        state, state_next;
  logic [1:0]    idx, idx_next;
  logic [TW-1:0] tcnt;

  // Frame assembly registers (data only, no reset needed).
  logic          addr_hi_bit;
  logic [7:0]    addr_lo;
  logic [31:0]   data_sr;
  logic [7:0]    ck_acc;

  // Per-cycle decisions from the next-state logic.
  logic          start_load, run_cmd, ck_good, ck_bad, tmo;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  always_comb begin
    state_next = state;
    idx_next   = idx;
    start_load = 1'b0;
    run_cmd    = 1'b0;
    ck_good    = 1'b0;
    ck_bad     = 1'b0;
    tmo        = 1'b0;
    if (state == S_IDLE) begin
      if (rx_valid) begin
        if (rx_data == SYNC_LOAD) begin
          start_load = 1'b1;
          state_next = S_ADDR_HI;
        end else if (rx_data == SYNC_RUN) begin
          run_cmd = 1'b1;
        end
      end
    end else if (rx_valid) begin
      // Inside a frame every byte is payload; sync values do not resync.
      case (state)
        S_ADDR_HI: state_next = S_ADDR_LO;
        S_ADDR_LO: begin
          state_next = S_DATA;
          idx_next   = 2'd0;
        end
        S_DATA: begin
          if (idx == 2'd3) state_next = S_CHECK;
          else             idx_next   = idx + 2'd1;
        end
        S_CHECK: begin
          if (rx_data == ck_acc) ck_good = 1'b1;
          else                   ck_bad  = 1'b1;
          state_next = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end else if (tcnt == T_LAST) begin
      // A byte arriving on the expiry cycle takes precedence (branch above).
      tmo        = 1'b1;
      state_next = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      idx   <= 2'd0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // ---- stage boundary: frame decision -> registered write/status outputs ----
  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt       <= '0;
      halt       <= HALT_ON_RESET;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= 2'b00;
      word_count <= '0;
    end else begin
      wr_en     <= ck_good;
      frame_ok  <= ck_good;
      frame_err <= ck_bad | tmo;
      if (ck_bad) err_code <= 2'b01;
      if (tmo)    err_code <= 2'b10;
      if (start_load) halt <= 1'b1;
      if (run_cmd)    halt <= 1'b0;
      if (state == S_IDLE || rx_valid || tmo) tcnt <= '0;
      else                                    tcnt <= tcnt + TW'(1);
      if (ck_good) begin
        wr_addr    <= {addr_hi_bit, addr_lo};
        wr_data    <= data_sr;
        word_count <= sat_inc(word_count);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rx_valid) begin
      case (state)
        S_IDLE:    ck_acc <= 8'h00;
        S_ADDR_HI: begin
          addr_hi_bit <= rx_data[0];
          ck_acc      <= ck_acc ^ rx_data;
        end
        S_ADDR_LO: begin
          addr_lo <= rx_data;
          ck_acc  <= ck_acc ^ rx_data;
        end
        S_DATA: begin
          data_sr <= {data_sr[23:0], rx_data};
          ck_acc  <= ck_acc ^ rx_data;
        end
        default: ;
      endcase
    end
  end

endmodule
